cam_capture_fmt: RTL

//  Parametrised OV7670 frame-capture front end in the CAM_PCLK domain. Packs the camera byte

---
 rtl/cam_capture_fmt.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cam_capture_fmt.sv
// OV7670 capture front end: packs camera bytes into DW-bit pixels, decimates, and writes
// them to the frame-buffer write port, with single-shot or continuous frame capture.
module cam_capture_fmt #(
    parameter int AW      = 15,
    parameter int DW      = 12,
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120
) (
    input  logic          CAM_PCLK,
    input  logic          rst_n,
    input  logic          CAM_VSYNC,
    input  logic          CAM_HREF,
    input  logic [7:0]    CAM_px_data,
    input  logic [1:0]    fmt_sel,
    input  logic [1:0]    decim,
    input  logic          video_en,
    input  logic          snap_req,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          busy,
    output logic          frame_done,
    output logic          overflow,
    output logic [7:0]    frame_cnt,
    output logic [2:0]    dbg_state_o
);

    localparam int MAX_PIX = H_PIX * V_LINES;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_WAIT_SOF, S_LINE_WAIT, S_BYTE0, S_BYTE1, S_HOLD
    } state_t;

    state_t        state_q;
    logic          vsync_q, href_q;
    logic [7:0]    b0_q;
    logic [1:0]    fmt_q, decim_q;
    logic [15:0]   col_q, line_q;
    logic [AW-1:0] addr_q;
    logic          full_q;
    logic [DW-1:0] data_q;
    logic          regw_q, busy_q, done_q, ovf_q;
    logic [7:0]    cnt_q;

    logic          vs_rise, vs_fall, href_rise, keep_d;
    logic [11:0]   pix_d;
    logic [15:0]   dmask_d, win_d;

    assign vs_rise   = CAM_VSYNC & ~vsync_q;
    assign vs_fall   = ~CAM_VSYNC & vsync_q;
    assign href_rise = CAM_HREF & ~href_q;

    // CAM_px_data is the second byte of the pixel while the FSM sits in BYTE0.
    always_comb begin
        pix_d = {b0_q[3:0], CAM_px_data};
        case (fmt_q)
            2'd1:    pix_d = {b0_q[7:4], b0_q[2:0], CAM_px_data[7], CAM_px_data[4:1]};
            2'd2:    pix_d = {3{b0_q[7:4]}};
            default: pix_d = {b0_q[3:0], CAM_px_data};
        endcase
    end

    always_comb begin
        dmask_d = (16'd1 << decim_q) - 16'd1;
        win_d   = 16'(H_PIX) << decim_q;
        keep_d  = ((col_q & dmask_d) == 16'd0) && ((line_q & dmask_d) == 16'd0) && (col_q < win_d);
    end

    // The RAM write port is valid-only: addr/data are valid in the cycle DP_RAM_regW is high
    // and the RAM always accepts, so there is no ready/backpressure path.
    always_ff @(posedge CAM_PCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            b0_q    <= '0;
            fmt_q   <= '0;
            decim_q <= '0;
            col_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            full_q  <= 1'b0;
            data_q  <= '0;
            regw_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vsync_q <= CAM_VSYNC;
            href_q  <= CAM_HREF;
            regw_q  <= 1'b0;
            done_q  <= 1'b0;
            // The address advances after the strobe cycle, so the RAM sees the written address.
            if (regw_q) begin
                if (addr_q == LAST_ADDR) full_q <= 1'b1;
                else                     addr_q <= addr_q + 1'b1;
            end
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (video_en || snap_req) begin
                        state_q <= S_ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (CAM_VSYNC) state_q <= S_WAIT_SOF;
                end
                S_WAIT_SOF: begin
                    if (vs_fall) begin
                        state_q <= S_LINE_WAIT;
                        fmt_q   <= fmt_sel;
                        decim_q <= decim;
                        addr_q  <= '0;
                        full_q  <= 1'b0;
                        col_q   <= '0;
                        line_q  <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_LINE_WAIT, S_BYTE0, S_BYTE1: begin
                    if (vs_rise) begin
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + 8'd1;
                        if (video_en) begin
                            state_q <= S_WAIT_SOF;
                        end else begin
                            state_q <= S_HOLD;
                            busy_q  <= 1'b0;
                        end
                    end else if (state_q == S_LINE_WAIT) begin
                        if (href_rise) begin
                            b0_q    <= CAM_px_data;
                            col_q   <= '0;
                            state_q <= S_BYTE0;
                        end
                    end else if (!CAM_HREF) begin
                        // A line ending in BYTE0 leaves a lone byte, which is simply discarded.
                        line_q  <= line_q + 16'd1;
                        state_q <= S_LINE_WAIT;
                    end else if (state_q == S_BYTE0) begin
                        state_q <= S_BYTE1;
                        if (keep_d) begin
                            if (full_q) begin
                                ovf_q <= 1'b1;
                            end else begin
                                regw_q <= 1'b1;
                                data_q <= DW'(pix_d);
                            end
                        end
                    end else begin
                        b0_q    <= CAM_px_data;
                        col_q   <= col_q + 16'd1;
                        state_q <= S_BYTE0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign DP_RAM_regW    = regw_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign overflow       = ovf_q;
    assign frame_cnt      = cnt_q;
    assign dbg_state_o    = state_q;

endmodule
